// File: rtl/e_mdu_if.sv
// -----------------------------------------------------------------------------
// e_mdu_if
//   Handshake/data bundle between the E stage and the multiply/divide unit.
//   Signals:
//     start  E-stage MD instruction valid this cycle (not flushed)
//     op     3-bit MD opcode (1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO)
//     a, b   forwarded rs / rt operands
//     busy   multiply/divide in flight
//     hi, lo architectural HI/LO registers
//   Modports:
//     master  issuing side (drives start/op/a/b, observes busy/hi/lo)
//     slave   the MDU itself
// -----------------------------------------------------------------------------
interface e_mdu_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, hi, lo
    );
endinterface

// File: rtl/e_mdu.sv
// -----------------------------------------------------------------------------
// e_mdu
//   Multi-cycle multiply/divide unit with HI/LO registers for the E stage of a
//   5-stage MIPS pipeline. MULT/MULTU/DIV/DIVU compute their result at the
//   accept edge into shadow registers, hold busy for MUL_CYCLES/DIV_CYCLES,
//   then commit to HI/LO. MTHI/MTLO write HI/LO directly when idle. Any start
//   while busy is ignored.
//   Ports:
//     clk    clock, rising edge
//     reset  synchronous, active-high
//     bus    e_mdu_if slave: start/op/a/b in, busy/hi/lo out (all registered)
// -----------------------------------------------------------------------------
module e_mdu #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic     clk,
    input  logic     reset,
    e_mdu_if.slave   bus
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rhi_q, rhi_d;
    logic [WIDTH-1:0] rlo_q, rlo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    // Set for a divide by zero: the op still runs its full latency but the
    // final commit is suppressed so HI/LO keep their old values.
    logic             skip_q, skip_d;

    // Signed divide built on magnitudes so truncation toward zero and the
    // remainder-follows-dividend rule fall out directly. The most-negative / -1
    // case needs no special handling: |MIN| / 1 negated wraps back to MIN, rem 0.
    // Returns {remainder, quotient}.
    function automatic logic [2*WIDTH-1:0] sdiv(input logic [WIDTH-1:0] n,
                                                input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] nm;
        logic [WIDTH-1:0] dm;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        nm = n[WIDTH-1] ? -n : n;
        dm = d[WIDTH-1] ? -d : d;
        q  = nm / dm;
        r  = nm % dm;
        if (n[WIDTH-1] ^ d[WIDTH-1]) q = -q;
        if (n[WIDTH-1])              r = -r;
        return {r, q};
    endfunction

    logic signed [2*WIDTH-1:0] prod_s;
    logic        [2*WIDTH-1:0] prod_u;
    logic        [WIDTH-1:0]   b_safe;
    logic        [2*WIDTH-1:0] div_s;
    logic        [WIDTH-1:0]   quo_u;
    logic        [WIDTH-1:0]   rem_u;
    logic                      b_zero;

    assign prod_s = $signed({{WIDTH{bus.a[WIDTH-1]}}, bus.a})
                  * $signed({{WIDTH{bus.b[WIDTH-1]}}, bus.b});
    assign prod_u = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};

    // Divisor forced to 1 on zero so the datapath never produces X; the
    // result is discarded anyway via skip.
    assign b_zero = (bus.b == '0);
    assign b_safe = b_zero ? WIDTH'(1) : bus.b;
    assign div_s  = sdiv(bus.a, b_safe);
    assign quo_u  = bus.a / b_safe;
    assign rem_u  = bus.a % b_safe;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rhi_d   = rhi_q;
        rlo_d   = rlo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        skip_d  = skip_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT: begin
                            {rhi_d, rlo_d} = prod_s;
                            cnt_d   = CNT_W'(MUL_CYCLES);
                            skip_d  = 1'b0;
                            state_d = RUN;
                        end
                        OP_MULTU: begin
                            {rhi_d, rlo_d} = prod_u;
                            cnt_d   = CNT_W'(MUL_CYCLES);
                            skip_d  = 1'b0;
                            state_d = RUN;
                        end
                        OP_DIV: begin
                            {rhi_d, rlo_d} = div_s;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            skip_d  = b_zero;
                            state_d = RUN;
                        end
                        OP_DIVU: begin
                            rhi_d   = rem_u;
                            rlo_d   = quo_u;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            skip_d  = b_zero;
                            state_d = RUN;
                        end
                        OP_MTHI: hi_d = bus.a;
                        OP_MTLO: lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Inputs are ignored here; the hazard unit should never issue
                // while busy, and if it does the running op must be unaffected.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    if (!skip_q) begin
                        hi_d = rhi_q;
                        lo_d = rlo_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rhi_q   <= '0;
            rlo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rhi_q   <= rhi_d;
            rlo_q   <= rlo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            skip_q  <= skip_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_e_mdu.sv
// -----------------------------------------------------------------------------
// tb_e_mdu
//   Scoreboard bench for e_mdu. Two instances: WIDTH=32 (MUL 5, DIV 10) and
//   WIDTH=16 (MUL 1, DIV 3). Stimulus pushes the expected commit (hi, lo, busy
//   length) into a queue; a monitor per instance measures each busy window and
//   compares HI/LO in the first idle cycle after it.
// -----------------------------------------------------------------------------
module tb_e_mdu;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    e_mdu_if #(.WIDTH(32)) bus32 ();
    e_mdu_if #(.WIDTH(16)) bus16 ();

    e_mdu #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut32 (
        .clk(clk), .reset(reset), .bus(bus32));
    e_mdu #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(3)) dut16 (
        .clk(clk), .reset(reset), .bus(bus16));

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];
    exp_t e32, e16;
    int   bc32 = 0;
    int   bc16 = 0;
    int   compared   = 0;
    int   mismatched = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic push32(input logic [31:0] h, input logic [31:0] l, input int c);
        exp_t e;
        e.hi = h; e.lo = l; e.cyc = c;
        q32.push_back(e);
    endtask

    task automatic push16(input logic [31:0] h, input logic [31:0] l, input int c);
        exp_t e;
        e.hi = h; e.lo = l; e.cyc = c;
        q16.push_back(e);
    endtask

    // Called at posedge+1; start is sampled on the next edge.
    task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus32.start = 1'b1; bus32.op = op; bus32.a = a; bus32.b = b;
        @(posedge clk); #1;
        bus32.start = 1'b0; bus32.op = 3'd0;
    endtask

    task automatic issue16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        bus16.start = 1'b1; bus16.op = op; bus16.a = a; bus16.b = b;
        @(posedge clk); #1;
        bus16.start = 1'b0; bus16.op = 3'd0;
    endtask

    task automatic wait_idle32(input string nm);
        for (int i = 0; i < 200; i++) begin
            if (!bus32.busy) return;
            @(posedge clk); #1;
        end
        compared++; mismatched++;
        $display("FAIL %s: busy still 1 after 200 cycles, required 0", nm);
    endtask

    task automatic wait_idle16(input string nm);
        for (int i = 0; i < 200; i++) begin
            if (!bus16.busy) return;
            @(posedge clk); #1;
        end
        compared++; mismatched++;
        $display("FAIL %s: busy still 1 after 200 cycles, required 0", nm);
    endtask

    // Monitor: count busy cycles; at the first idle sample compare the commit.
    initial forever begin
        @(negedge clk);
        if (reset) bc32 = 0;
        else if (bus32.busy) bc32++;
        else if (bc32 > 0) begin
            if (q32.size() == 0) begin
                compared++; mismatched++;
                $display("FAIL commit32_unexpected: busy window %0d cycles, none expected", bc32);
            end else begin
                e32 = q32.pop_front();
                chk("commit32_busy_len", 32'(bc32), 32'(e32.cyc));
                chk("commit32_hi", bus32.hi, e32.hi);
                chk("commit32_lo", bus32.lo, e32.lo);
            end
            bc32 = 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (reset) bc16 = 0;
        else if (bus16.busy) bc16++;
        else if (bc16 > 0) begin
            if (q16.size() == 0) begin
                compared++; mismatched++;
                $display("FAIL commit16_unexpected: busy window %0d cycles, none expected", bc16);
            end else begin
                e16 = q16.pop_front();
                chk("commit16_busy_len", 32'(bc16), 32'(e16.cyc));
                chk("commit16_hi", 32'(bus16.hi), e16.hi);
                chk("commit16_lo", 32'(bus16.lo), e16.lo);
            end
            bc16 = 0;
        end
    end

    initial begin
        bus32.start = 1'b0; bus32.op = 3'd0; bus32.a = '0; bus32.b = '0;
        bus16.start = 1'b0; bus16.op = 3'd0; bus16.a = '0; bus16.b = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_busy", 32'(bus32.busy), 32'd0);
        chk("reset_hi", bus32.hi, 32'h0);
        chk("reset_lo", bus32.lo, 32'h0);

        // MTHI / MTLO in idle
        issue32(3'd5, 32'h12345678, 32'h0);
        chk("mthi_hi", bus32.hi, 32'h12345678);
        chk("mthi_busy", 32'(bus32.busy), 32'd0);
        issue32(3'd6, 32'h0BADF00D, 32'h0);
        chk("mtlo_lo", bus32.lo, 32'h0BADF00D);

        // Reset mid-DIV at cnt=4: nothing commits, HI/LO cleared
        issue32(3'd3, 32'd100, 32'd3);
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("rst_mid_busy", 32'(bus32.busy), 32'd0);
        chk("rst_mid_hi", bus32.hi, 32'h0);
        chk("rst_mid_lo", bus32.lo, 32'h0);
        repeat (12) @(posedge clk); #1;
        chk("rst_late_busy", 32'(bus32.busy), 32'd0);
        chk("rst_late_hi", bus32.hi, 32'h0);
        chk("rst_late_lo", bus32.lo, 32'h0);

        // MULT / MULTU
        push32(32'hFFFFFFFF, 32'hFFFFFFFE, 5);
        issue32(3'd1, 32'hFFFFFFFF, 32'h2);
        wait_idle32("mult");
        push32(32'h00000001, 32'hFFFFFFFE, 5);
        issue32(3'd2, 32'hFFFFFFFF, 32'h2);
        wait_idle32("multu");

        // DIV / DIVU
        push32(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        issue32(3'd3, 32'hFFFFFFF9, 32'h2);
        wait_idle32("div");
        push32(32'h1, 32'h3, 10);
        issue32(3'd4, 32'h7, 32'h2);
        wait_idle32("divu");

        // Divide by zero leaves HI/LO alone
        issue32(3'd5, 32'hAAAA0000, 32'h0);
        issue32(3'd6, 32'h0000BBBB, 32'h0);
        push32(32'hAAAA0000, 32'h0000BBBB, 10);
        issue32(3'd3, 32'h1234, 32'h0);
        wait_idle32("div0");

        // MTLO while busy is ignored; running MULT commits normally
        push32(32'h0, 32'd15, 5);
        issue32(3'd1, 32'd3, 32'd5);
        issue32(3'd6, 32'h0000DEAD, 32'h0);
        chk("mtlo_busy_lo", bus32.lo, 32'h0000BBBB);
        chk("mtlo_busy_busy", 32'(bus32.busy), 32'd1);
        wait_idle32("mult_mtlo");

        // Back-to-back: DIVU in the first idle cycle after a MULT commit
        push32(32'h1, 32'h0, 5);
        issue32(3'd1, 32'h00010000, 32'h00010000);
        wait_idle32("b2b_mult");
        push32(32'd2, 32'd14, 10);
        issue32(3'd4, 32'd100, 32'd7);
        chk("b2b_divu_accepted", 32'(bus32.busy), 32'd1);
        wait_idle32("b2b_divu");

        // Ops 0 and 7 are no-ops
        issue32(3'd0, 32'h5555, 32'h1);
        chk("op0_busy", 32'(bus32.busy), 32'd0);
        chk("op0_hi", bus32.hi, 32'd2);
        chk("op0_lo", bus32.lo, 32'd14);
        issue32(3'd7, 32'h5555, 32'h1);
        chk("op7_busy", 32'(bus32.busy), 32'd0);
        chk("op7_lo", bus32.lo, 32'd14);

        // Signed overflow
        push32(32'h0, 32'h80000000, 10);
        issue32(3'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_idle32("div_ovf");

        // WIDTH=16, MUL_CYCLES=1
        push16(32'hFFFF, 32'hFFFE, 1);
        issue16(3'd1, 16'hFFFF, 16'h2);
        chk("w16_mult_busy", 32'(bus16.busy), 32'd1);
        wait_idle16("w16_mult");
        push16(32'h1, 32'hFFFE, 1);
        issue16(3'd2, 16'hFFFF, 16'h2);
        wait_idle16("w16_multu");
        push16(32'hFFFF, 32'hFFFD, 3);
        issue16(3'd3, 16'hFFF9, 16'h2);
        wait_idle16("w16_div");

        repeat (3) @(posedge clk); #1;
        chk("q32_drained", 32'(q32.size()), 32'd0);
        chk("q16_drained", 32'(q16.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
